// File: rtl/reg_stat_multi_pkg.sv
// reg_stat_multi_pkg: shared tag constant, widths and default parameters for the register status table
package reg_stat_multi_pkg;
  localparam int NREG_DEF  = 32;
  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 4;
  localparam int NLANE_DEF = 2;
  localparam int NWB_DEF   = 4;
  localparam int UNLOCKED  = 0;
  typedef logic [XLEN_DEF-1:0] word_t;
  typedef logic [$clog2(NREG_DEF)-1:0] regaddr_t;
  typedef logic [TAG_W_DEF-1:0] regtag_t;
endpackage

// File: rtl/reg_stat_read_port.sv
// reg_stat_read_port: one source operand mux (immediate / table / bypass / intra-bundle override)
// Ports: en, addr select the source; imm replaces a disabled read; tbl_data/tbl_tag are the
// stored entry; byp_hit/byp_data forward a same-cycle writeback; ovr_hit/ovr_tag carry a
// rename from an earlier lane of the bundle; data/tag are the resolved operand.
module reg_stat_read_port
  import reg_stat_multi_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int AW    = $clog2(NREG_DEF)
) (
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  tbl_data,
  input  logic [TAG_W-1:0] tbl_tag,
  input  logic             byp_hit,
  input  logic [XLEN-1:0]  byp_data,
  input  logic             ovr_hit,
  input  logic [TAG_W-1:0] ovr_tag,
  output logic [XLEN-1:0]  data,
  output logic [TAG_W-1:0] tag
);
  // an earlier-lane rename outranks forwarding: the consumer must wait for the new producer
  assign data = !en ? imm : (addr == '0) ? '0 : (byp_hit && !ovr_hit) ? byp_data : tbl_data;
  assign tag  = (!en || addr == '0) ? TAG_W'(UNLOCKED) : ovr_hit ? ovr_tag :
                byp_hit ? TAG_W'(UNLOCKED) : tbl_tag;
endmodule

// File: rtl/reg_stat_multi.sv
// reg_stat_multi: register value + producer-tag table serving an NLANE dispatch bundle against NWB writeback channels
// Ports: clk, rst_n (sync, active low), rdy (hold when low), flush (clear all tags);
// rs_en/rs_addr/rs_imm -> rs_data/rs_tag: 2*NLANE combinational source reads;
// rd_en/rd_addr/rd_tag: per-lane renames; wb_en/wb_tag/wb_addr/wb_data: tag-matched writebacks;
// locked_cnt: registered number of registers with a nonzero tag.
// Build option: define REG_STAT_BYPASS_EN to forward matching writebacks to reads in the same cycle.
module reg_stat_multi
  import reg_stat_multi_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NLANE = NLANE_DEF,
  parameter int NWB   = NWB_DEF,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic [2*NLANE-1:0]        rs_en,
  input  logic [2*NLANE*AW-1:0]     rs_addr,
  input  logic [NLANE*XLEN-1:0]     rs_imm,
  output logic [2*NLANE*XLEN-1:0]   rs_data,
  output logic [2*NLANE*TAG_W-1:0]  rs_tag,
  input  logic [NLANE-1:0]          rd_en,
  input  logic [NLANE*AW-1:0]       rd_addr,
  input  logic [NLANE*TAG_W-1:0]    rd_tag,
  input  logic [NWB-1:0]            wb_en,
  input  logic [NWB*TAG_W-1:0]      wb_tag,
  input  logic [NWB*AW-1:0]         wb_addr,
  input  logic [NWB*XLEN-1:0]       wb_data,
  output logic [CW-1:0]             locked_cnt
);
  logic [XLEN-1:0]  data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [XLEN-1:0]  data_d [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [CW-1:0]    cnt_d;
  logic [NWB-1:0]   wb_m;
  logic             dup;
  // a writeback only lands if it comes from the register's current producer
  always_comb begin
    wb_m = '0;
    for (int k = 0; k < NWB; k++)
      wb_m[k] = wb_en[k] && wb_addr[k*AW +: AW] != '0 && wb_tag[k*TAG_W +: TAG_W] != TAG_W'(UNLOCKED) &&
                tag_q[wb_addr[k*AW +: AW]] == wb_tag[k*TAG_W +: TAG_W];
  end
  always_comb begin
    data_d = data_q;
    tag_d = tag_q;
    dup = 1'b0;
    cnt_d = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wb_m[k]) begin
        data_d[wb_addr[k*AW +: AW]] = wb_data[k*XLEN +: XLEN];
        tag_d[wb_addr[k*AW +: AW]] = TAG_W'(UNLOCKED);
      end
      for (int m = k + 1; m < NWB; m++)
        if (wb_m[k] && wb_m[m] && wb_addr[k*AW +: AW] == wb_addr[m*AW +: AW]) dup = 1'b1;
    end
    // renames run after writebacks so a same-cycle rename keeps its new tag; later lanes win
    for (int l = 0; l < NLANE; l++)
      if (!flush && rd_en[l] && rd_addr[l*AW +: AW] != '0)
        tag_d[rd_addr[l*AW +: AW]] = rd_tag[l*TAG_W +: TAG_W];
    for (int r = 0; r < NREG; r++) begin
      if (flush) tag_d[r] = TAG_W'(UNLOCKED);
      cnt_d = cnt_d + CW'(tag_d[r] != TAG_W'(UNLOCKED));
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r] <= '0;
      end
      locked_cnt <= '0;
    end else if (rdy) begin
      data_q <= data_d;
      tag_q <= tag_d;
      locked_cnt <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (rst_n && rdy) assert (!dup);
  for (genvar s = 0; s < 2*NLANE; s++) begin : g_rd
    localparam int L = s / 2;
    logic [AW-1:0]    a;
    logic             byp_hit;
    logic [XLEN-1:0]  byp_data;
    logic             ovr_hit;
    logic [TAG_W-1:0] ovr_tag;
    assign a = rs_addr[s*AW +: AW];
    always_comb begin
      ovr_hit = 1'b0;
      ovr_tag = '0;
      for (int i = 0; i < L; i++)
        if (rd_en[i] && a != '0 && rd_addr[i*AW +: AW] == a) begin
          ovr_hit = 1'b1;
          ovr_tag = rd_tag[i*TAG_W +: TAG_W];
        end
    end
`ifdef REG_STAT_BYPASS_EN
    always_comb begin
      byp_hit = 1'b0;
      byp_data = '0;
      for (int k = 0; k < NWB; k++)
        if (wb_m[k] && wb_addr[k*AW +: AW] == a) begin
          byp_hit = 1'b1;
          byp_data = wb_data[k*XLEN +: XLEN];
        end
    end
`else
    assign byp_hit = 1'b0;
    assign byp_data = '0;
`endif
    reg_stat_read_port #(.XLEN(XLEN), .TAG_W(TAG_W), .AW(AW)) u_port (
      .en(rs_en[s]),
      .addr(a),
      .imm(rs_imm[L*XLEN +: XLEN]),
      .tbl_data(data_q[a]),
      .tbl_tag(tag_q[a]),
      .byp_hit(byp_hit),
      .byp_data(byp_data),
      .ovr_hit(ovr_hit),
      .ovr_tag(ovr_tag),
      .data(rs_data[s*XLEN +: XLEN]),
      .tag(rs_tag[s*TAG_W +: TAG_W])
    );
  end
endmodule

// File: doc/reg_stat_multi.md
# reg_stat_multi

Parametrised register status table for the dispatch stage: holds architectural register values plus a producer tag per register, and services an N-lane dispatch bundle (two source reads and one destination rename per lane) against W tag-matched writeback channels. Successor to the fixed two-read, one-rename, four-unit table: producer identity becomes a free tag carried on each writeback channel, and this block adds intra-bundle dependency resolution, a global flush and a registered locked-register count. It sits between decode and the reservation stations.

## Interface
- `NREG`, 32: architectural registers; x0 hardwired zero.
- `XLEN`, 32: data width.
- `TAG_W`, 4: tag width; tag 0 = `UNLOCKED`.
- `NLANE`, 2: dispatch lanes per cycle.
- `NWB`, 4: writeback channels.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rdy`  in  1  global enable; low = hold all state.
- `flush`  in  1  squash all outstanding renames.
- `rs_en`  in  2·NLANE  per-source read enable (lane l: bit 2l = rs1, bit 2l+1 = rs2).
- `rs_addr`  in  2·NLANE·log2(NREG)  source addresses.
- `rs_imm`  in  NLANE·XLEN  per-lane immediate substituted when a read is disabled.
- `rs_data`  out  2·NLANE·XLEN  source value.
- `rs_tag`  out  2·NLANE·TAG_W  source producer tag; 0 = data valid.
- `rd_en`  in  NLANE  rename request.
- `rd_addr`  in  NLANE·log2(NREG)  destination.
- `rd_tag`  in  NLANE·TAG_W  new producer tag (nonzero).
- `wb_en`  in  NWB  writeback valid.
- `wb_tag`  in  NWB·TAG_W  producer tag.
- `wb_addr`  in  NWB·log2(NREG)  destination register.
- `wb_data`  in  NWB·XLEN  result.
- `locked_cnt`  out  log2(NREG+1)  registered count of locked registers.

## Operation
- Read (combinational, from current state): disabled source → {`rs_imm` of its lane, 0}. Enabled → {data[a], tag[a]}; a = 0 always gives {0, 0}.
- Intra-bundle: source of lane j whose address equals `rd_addr` of an enabled lane i < j (a ≠ 0) returns tag `rd_tag[i]`; the highest such i wins. Overrides bypass.
- Rename: `rd_en[l]` with addr ≠ 0 sets tag[addr] ← `rd_tag[l]`; same addr on several lanes → highest lane wins.
- Writeback: channel k with addr ≠ 0 and tag[addr] == `wb_tag[k]` writes data[addr] ← `wb_data[k]` and sets tag ← 0, unless the same register is renamed this cycle (data still written; tag takes rename value). Non-matching tag → ignored (stale producer).
- Two channels matching the same register in one cycle: illegal; simulation assertion.
- Flush: all tags ← 0; matching writebacks still update data; renames that cycle discarded.
- `locked_cnt` ← popcount of next-state tags ≠ 0.
- `rdy` low: no state change; read outputs remain combinational.

## Timing
- Reads: zero-cycle combinational.
- Rename/writeback/flush: visible on reads in the cycle after the edge.
- `locked_cnt`: reflects state after the same edge (tracks table exactly, no extra lag).
- Reset (`rst_n` low at edge, overrides `rdy` and `flush`): all data 0, all tags 0, `locked_cnt` 0.
- Reset mid-bundle: in-flight renames lost; subsequent writebacks with stale tags ignored.

## Configuration
- `REG_STAT_BYPASS_EN` defined: an enabled read whose current tag matches a valid `wb_tag` this cycle returns {`wb_data`, 0} (same-cycle forwarding).
- Undefined: read returns stored {data, tag}; consumer catches result from the writeback bus next cycle.

## Structure
- Shared package: `UNLOCKED` tag constant, `word_t`/`regaddr_t`/`regtag_t` widths, default parameter values.
- One sub-module, `reg_stat_read_port`: per-source mux (immediate/table/bypass/intra-bundle override), instantiated 2·NLANE times.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all reads {0,0}, `locked_cnt`=0.
- Rename x5→tag 3, next cycle wb tag 3 data 0xDEAD_BEEF → read x5 gives {0xDEADBEEF,0}, `locked_cnt` 1→0.
- Stale writeback: rename x5 tag 3 then tag 7; wb tag 3 → x5 still tag 7, data unchanged.
- Same cycle rename x6 tag 2 and wb x6 tag 1 (held) → tag 2, data = wb value.
- Lane0 rd x7 tag 4, lane1 rs1 x7 → lane1 tag 4; lane0/1 both rd x7 → tag from lane1.
- Flush with 3 locked regs and wb matching one → all tags 0, matched data written, `locked_cnt` 0; with bypass macro, read of x9 (tag 5) while wb tag 5 → {wb_data,0} same cycle.
